// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode classes, instruction field
// positions, reset PC default and the fetch buffer entry layout.
package cpu_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] OP_CODE_DP  = 2'b00;
    localparam logic [1:0] OP_CODE_MEM = 2'b01;
    localparam logic [1:0] OP_CODE_B   = 2'b10;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: generic synchronous FIFO with a flush that overrides same-cycle push/pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: readers qualify the head with empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Purpose: PC owner and in-order instruction fetcher feeding decode, with redirect flush.
// Latency: response in cycle N is offered to decode in N+1; 2 cycles + memory latency minimum.
// Backpressure: requests stop when inflight + buffered reaches DEPTH; decode stalls via instr_ready.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus8,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              run;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     buf_count;
    logic              buf_empty;
    logic              tag_empty;
    logic [ADDR_W-1:0] tag_head;
    fetch_entry_t      buf_head;
    fetch_entry_t      buf_push;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_keep;
    logic              pop;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Buffered words and words still in flight share the same DEPTH credits.
    assign imem_req_valid = run && !redirect && ((inflight + buf_count) < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && !tag_empty;
    assign rsp_keep       = rsp_take && (drop == '0);
    assign pop            = instr_valid && instr_ready;
    assign buf_push.instr = imem_rsp_data;
    assign buf_push.pc    = PC_W'(tag_head);

    // The tag queue is never flushed: dropped responses still pop it.
    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (req_fire),
        .push_dat (fetch_pc),
        .pop      (rsp_take),
        .head_dat (tag_head),
        .empty    (tag_empty),
        .count    (inflight)
    );

    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (rsp_keep),
        .push_dat (buf_push),
        .pop      (pop),
        .head_dat (buf_head),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
                drop     <= inflight - CW'(rsp_take);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    assign instr_valid    = !buf_empty;
    assign instr          = buf_empty ? '0 : buf_head.instr;
    assign instr_pc       = buf_empty ? '0 : ADDR_W'(buf_head.pc);
    assign instr_pc_plus8 = buf_empty ? '0 : instr_pc + ADDR_W'(8);
    assign cond           = instr[COND_MSB:COND_LSB];
    assign op             = instr[OP_MSB:OP_LSB];
    assign funct          = instr[FUNCT_MSB:FUNCT_LSB];
    assign rd             = instr[RD_MSB:RD_LSB];

endmodule
